// File: rtl/instruction_decode_pkg.sv
// Shared MIPS decode constants, default widths and instruction field helpers.
package instruction_decode_pkg;

    localparam int unsigned IWIDTH_DEF   = 32;
    localparam int unsigned PC_WIDTH_DEF = 32;
    localparam int unsigned DWIDTH_DEF   = 32;
    localparam int unsigned AWIDTH_DEF   = 5;

    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_JR     = 6'h08;

    localparam logic [4:0] REG_RA    = 5'd31;

    // Fixed R-format view of a 32-bit instruction word.
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } r_fields_t;

    typedef enum logic [1:0] {
        IMM_SIGN  = 2'd0,
        IMM_ZERO  = 2'd1,
        IMM_UPPER = 2'd2
    } imm_kind_e;

    // Selects how the 16-bit immediate is widened for a given opcode.
    function automatic imm_kind_e imm_kind(input logic [5:0] opcode);
        imm_kind_e kind;
        kind = IMM_SIGN;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: kind = IMM_ZERO;
            OP_LUI:                   kind = IMM_UPPER;
            default:                  kind = IMM_SIGN;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 2-read/1-write register file with zero register and write-through bypass.
module register_file
    import instruction_decode_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr_a,
    input  logic [AWIDTH-1:0] raddr_b,
    output logic [DWIDTH-1:0] rdata_a_c,
    output logic [DWIDTH-1:0] rdata_b_c
);

    localparam int unsigned NUM_REGS = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [NUM_REGS];

    // Array storage: cleared on reset, register 0 never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: r0 is hard zero, a same-cycle write is forwarded.
    always_comb begin
        rdata_a_c = '0;
        rdata_b_c = '0;
        if (raddr_a != '0) begin
            rdata_a_c = (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
        end
        if (raddr_b != '0) begin
            rdata_b_c = (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// MIPS decode stage: field split, operand read, immediate/jump formation and ID/EX register.
module instruction_decode
    import instruction_decode_pkg::*;
#(
    parameter int unsigned IWIDTH   = IWIDTH_DEF,
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEF,
    parameter int unsigned DWIDTH   = DWIDTH_DEF,
    parameter int unsigned AWIDTH   = AWIDTH_DEF
) (
    input  logic                d_clk,
    input  logic                d_rst,
    input  logic                d_i_ce,
    input  logic [IWIDTH-1:0]   d_i_instr,
    input  logic [PC_WIDTH-1:0] d_i_pc,
    input  logic                d_i_stall,
    input  logic                d_i_flush,
    input  logic                d_i_we,
    input  logic [AWIDTH-1:0]   d_i_waddr,
    input  logic [DWIDTH-1:0]   d_i_wdata,
    output logic                d_o_ce,
    output logic [PC_WIDTH-1:0] d_o_pc,
    output logic [5:0]          d_o_opcode,
    output logic [5:0]          d_o_funct,
    output logic [4:0]          d_o_shamt,
    output logic [AWIDTH-1:0]   d_o_rs_addr,
    output logic [AWIDTH-1:0]   d_o_rt_addr,
    output logic [AWIDTH-1:0]   d_o_rd_addr,
    output logic [DWIDTH-1:0]   d_o_rs_data,
    output logic [DWIDTH-1:0]   d_o_rt_data,
    output logic [DWIDTH-1:0]   d_o_imm,
    output logic [PC_WIDTH-1:0] d_o_jump_target,
    output logic                d_o_reg_write,
    output logic                d_o_illegal
);

    typedef struct packed {
        logic                ce;
        logic [PC_WIDTH-1:0] pc;
        logic [5:0]          opcode;
        logic [5:0]          funct;
        logic [4:0]          shamt;
        logic [AWIDTH-1:0]   rs_addr;
        logic [AWIDTH-1:0]   rt_addr;
        logic [AWIDTH-1:0]   rd_addr;
        logic [DWIDTH-1:0]   rs_data;
        logic [DWIDTH-1:0]   rt_data;
        logic [DWIDTH-1:0]   imm;
        logic [PC_WIDTH-1:0] jump_target;
        logic                reg_write;
        logic                illegal;
    } stage_t;

    r_fields_t           fields_c;
    logic [15:0]         imm16_c;
    logic [25:0]         target26_c;
    logic [AWIDTH-1:0]   rs_addr_c;
    logic [AWIDTH-1:0]   rt_addr_c;
    logic [DWIDTH-1:0]   rs_data_c;
    logic [DWIDTH-1:0]   rt_data_c;
    logic [DWIDTH-1:0]   imm_c;
    logic [PC_WIDTH-1:0] pc_plus4_c;
    logic [PC_WIDTH-1:0] jump_target_c;
    logic [AWIDTH-1:0]   dest_c;
    logic                writes_c;
    logic                illegal_c;
    logic                bubble_c;
    logic                rs_fwd_c;
    logic                rt_fwd_c;
    stage_t              stage_d_c;
    stage_t              stage_q;

    assign fields_c   = r_fields_t'(d_i_instr[31:0]);
    assign imm16_c    = d_i_instr[15:0];
    assign target26_c = d_i_instr[25:0];
    assign rs_addr_c  = AWIDTH'(fields_c.rs);
    assign rt_addr_c  = AWIDTH'(fields_c.rt);

    register_file #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_register_file (
        .clk       (d_clk),
        .rst_n     (d_rst),
        .we        (d_i_we),
        .waddr     (d_i_waddr),
        .wdata     (d_i_wdata),
        .raddr_a   (rs_addr_c),
        .raddr_b   (rt_addr_c),
        .rdata_a_c (rs_data_c),
        .rdata_b_c (rt_data_c)
    );

    // Immediate widening by opcode class.
    always_comb begin
        imm_c = {{(DWIDTH-16){imm16_c[15]}}, imm16_c};
        case (imm_kind(fields_c.opcode))
            IMM_ZERO:  imm_c = DWIDTH'(imm16_c);
            IMM_UPPER: imm_c = DWIDTH'({imm16_c, 16'h0000});
            default:   imm_c = {{(DWIDTH-16){imm16_c[15]}}, imm16_c};
        endcase
    end

    // Jump target keeps the top nibble of the sequential PC.
    always_comb begin
        pc_plus4_c    = d_i_pc + PC_WIDTH'(4);
        jump_target_c = (pc_plus4_c & ~PC_WIDTH'(32'h0FFF_FFFF))
                      | PC_WIDTH'({target26_c, 2'b00});
    end

    // Destination resolution, write enable and legality.
    always_comb begin
        dest_c    = '0;
        writes_c  = 1'b0;
        illegal_c = 1'b0;
        case (fields_c.opcode)
            OP_R_TYPE: begin
                dest_c   = AWIDTH'(fields_c.rd);
                writes_c = (fields_c.funct != FN_JR);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                dest_c   = rt_addr_c;
                writes_c = 1'b1;
            end
            OP_JAL: begin
                dest_c   = AWIDTH'(REG_RA);
                writes_c = 1'b1;
            end
            OP_J, OP_BEQ, OP_BNE, OP_SW: begin
                writes_c = 1'b0;
            end
            default: begin
                illegal_c = 1'b1;
            end
        endcase
    end

    // Next pipeline-register contents and stall-time writeback forwarding.
    always_comb begin
        stage_d_c             = '0;
        stage_d_c.ce          = 1'b1;
        stage_d_c.pc          = d_i_pc;
        stage_d_c.opcode      = fields_c.opcode;
        stage_d_c.funct       = fields_c.funct;
        stage_d_c.shamt       = fields_c.shamt;
        stage_d_c.rs_addr     = rs_addr_c;
        stage_d_c.rt_addr     = rt_addr_c;
        stage_d_c.rd_addr     = dest_c;
        stage_d_c.rs_data     = rs_data_c;
        stage_d_c.rt_data     = rt_data_c;
        stage_d_c.imm         = imm_c;
        stage_d_c.jump_target = jump_target_c;
        stage_d_c.reg_write   = writes_c && (dest_c != '0);
        stage_d_c.illegal     = illegal_c;

        bubble_c = d_i_flush || (!d_i_stall && !d_i_ce);
        rs_fwd_c = d_i_we && (d_i_waddr != '0) && (d_i_waddr == stage_q.rs_addr);
        rt_fwd_c = d_i_we && (d_i_waddr != '0) && (d_i_waddr == stage_q.rt_addr);
    end

    // ID/EX register: flush > stall (with operand refresh) > bubble > load.
    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            stage_q <= '0;
        end else if (bubble_c) begin
            stage_q <= '0;
        end else if (d_i_stall) begin
            if (rs_fwd_c) begin
                stage_q.rs_data <= d_i_wdata;
            end
            if (rt_fwd_c) begin
                stage_q.rt_data <= d_i_wdata;
            end
        end else begin
            stage_q <= stage_d_c;
        end
    end

    assign d_o_ce          = stage_q.ce;
    assign d_o_pc          = stage_q.pc;
    assign d_o_opcode      = stage_q.opcode;
    assign d_o_funct       = stage_q.funct;
    assign d_o_shamt       = stage_q.shamt;
    assign d_o_rs_addr     = stage_q.rs_addr;
    assign d_o_rt_addr     = stage_q.rt_addr;
    assign d_o_rd_addr     = stage_q.rd_addr;
    assign d_o_rs_data     = stage_q.rs_data;
    assign d_o_rt_data     = stage_q.rt_data;
    assign d_o_imm         = stage_q.imm;
    assign d_o_jump_target = stage_q.jump_target;
    assign d_o_reg_write   = stage_q.reg_write;
    assign d_o_illegal     = stage_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: constant vector table, hand sequences, random vs. reference model.
module tb_instruction_decode;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] jt;
        logic        rw;
        logic        ill;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ce;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        out_t        exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    logic        o_ce;
    logic [31:0] o_pc;
    logic [5:0]  o_opcode;
    logic [5:0]  o_funct;
    logic [4:0]  o_shamt;
    logic [4:0]  o_rs_addr;
    logic [4:0]  o_rt_addr;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rs_data;
    logic [31:0] o_rt_data;
    logic [31:0] o_imm;
    logic [31:0] o_jt;
    logic        o_rw;
    logic        o_ill;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_rf [32];
    out_t        m_q;

    instruction_decode dut (
        .d_clk           (clk),
        .d_rst           (rst),
        .d_i_ce          (ce),
        .d_i_instr       (instr),
        .d_i_pc          (pc),
        .d_i_stall       (stall),
        .d_i_flush       (flush),
        .d_i_we          (we),
        .d_i_waddr       (waddr),
        .d_i_wdata       (wdata),
        .d_o_ce          (o_ce),
        .d_o_pc          (o_pc),
        .d_o_opcode      (o_opcode),
        .d_o_funct       (o_funct),
        .d_o_shamt       (o_shamt),
        .d_o_rs_addr     (o_rs_addr),
        .d_o_rt_addr     (o_rt_addr),
        .d_o_rd_addr     (o_rd_addr),
        .d_o_rs_data     (o_rs_data),
        .d_o_rt_data     (o_rt_data),
        .d_o_imm         (o_imm),
        .d_o_jump_target (o_jt),
        .d_o_reg_write   (o_rw),
        .d_o_illegal     (o_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic c, input logic [31:0] p, input logic [5:0] op,
                                input logic [5:0] fn, input logic [4:0] sh, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                                input logic [31:0] rtd, input logic [31:0] im, input logic [31:0] j,
                                input logic w, input logic il);
        out_t r;
        r = {c, p, op, fn, sh, rs, rt, rd, rsd, rtd, im, j, w, il};
        return r;
    endfunction

    // Reference decode written from the instruction-set rules.
    function automatic out_t model_decode(input logic [31:0] i, input logic [31:0] p);
        out_t        r;
        int          op;
        logic [31:0] imm16;
        logic [4:0]  dest;
        logic        writes;
        r      = '0;
        op     = int'(i[31:26]);
        imm16  = {16'h0, i[15:0]};
        dest   = 5'd0;
        writes = 1'b0;
        r.ce      = 1'b1;
        r.pc      = p;
        r.opcode  = i[31:26];
        r.funct   = i[5:0];
        r.shamt   = i[10:6];
        r.rs      = i[25:21];
        r.rt      = i[20:16];
        if (op == 12 || op == 13 || op == 14) r.imm = imm16;
        else if (op == 15)                    r.imm = imm16 * 32'd65536;
        else if (imm16 >= 32'd32768)          r.imm = imm16 + 32'hFFFF0000;
        else                                  r.imm = imm16;
        r.jt = ((p + 32'd4) & 32'hF000_0000) | ((i & 32'h03FF_FFFF) * 32'd4);
        if (op == 0) begin
            dest = i[15:11];
            writes = (i[5:0] != 6'd8);
        end else if ((op >= 8 && op <= 15) || op == 35) begin
            dest = i[20:16];
            writes = 1'b1;
        end else if (op == 3) begin
            dest = 5'd31;
            writes = 1'b1;
        end else if (op == 2 || op == 4 || op == 5 || op == 43) begin
            writes = 1'b0;
        end else begin
            r.ill = 1'b1;
        end
        r.rd      = dest;
        r.rw      = writes && (dest != 5'd0);
        r.rs_data = m_rf[r.rs];
        r.rt_data = m_rf[r.rt];
        return r;
    endfunction

    // Advances the model by one clock edge using the currently driven inputs.
    function automatic void model_step();
        if (!rst) begin
            m_q = '0;
            for (int k = 0; k < 32; k++) m_rf[k] = '0;
        end else begin
            if (we && waddr != 5'd0) m_rf[waddr] = wdata;
            if (flush) begin
                m_q = '0;
            end else if (stall) begin
                if (we && waddr != 5'd0 && waddr == m_q.rs) m_q.rs_data = wdata;
                if (we && waddr != 5'd0 && waddr == m_q.rt) m_q.rt_data = wdata;
            end else if (!ce) begin
                m_q = '0;
            end else begin
                m_q = model_decode(instr, pc);
            end
        end
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic c,
                         input logic s, input logic f, input logic w,
                         input logic [4:0] wa, input logic [31:0] wd);
        instr = i; pc = p; ce = c; stall = s; flush = f; we = w; waddr = wa; wdata = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input out_t want);
        out_t got;
        got = {o_ce, o_pc, o_opcode, o_funct, o_shamt, o_rs_addr, o_rt_addr, o_rd_addr,
               o_rs_data, o_rt_data, o_imm, o_jt, o_rw, o_ill};
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    vec_t vecs[$];
    out_t hold;

    initial begin
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        m_q = '0;
        for (int k = 0; k < 32; k++) m_rf[k] = '0;

        vecs.push_back('{32'h00221820, 32'h00400000, 1, 0, 5'd0, 32'h0,
            mk(1, 32'h00400000, 6'h00, 6'h20, 5'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h00001820, 32'h00886080, 1, 0)});
        vecs.push_back('{32'h2022FFFF, 32'h00400004, 1, 0, 5'd0, 32'h0,
            mk(1, 32'h00400004, 6'h08, 6'h3F, 5'd31, 5'd1, 5'd2, 5'd2, 32'd5, 32'd7, 32'hFFFFFFFF, 32'h008BFFFC, 1, 0)});
        vecs.push_back('{32'h3422FFFF, 32'h00400008, 1, 0, 5'd0, 32'h0,
            mk(1, 32'h00400008, 6'h0D, 6'h3F, 5'd31, 5'd1, 5'd2, 5'd2, 32'd5, 32'd7, 32'h0000FFFF, 32'h008BFFFC, 1, 0)});
        vecs.push_back('{32'h3C011234, 32'h0040000C, 1, 0, 5'd0, 32'h0,
            mk(1, 32'h0040000C, 6'h0F, 6'h34, 5'd8, 5'd0, 5'd1, 5'd1, 32'd0, 32'd5, 32'h12340000, 32'h000448D0, 1, 0)});
        vecs.push_back('{32'h00221820, 32'h00400010, 1, 1, 5'd1, 32'hDEADBEEF,
            mk(1, 32'h00400010, 6'h00, 6'h20, 5'd0, 5'd1, 5'd2, 5'd3, 32'hDEADBEEF, 32'd7, 32'h00001820, 32'h00886080, 1, 0)});
        vecs.push_back('{32'h0C100004, 32'h00400008, 1, 0, 5'd0, 32'h0,
            mk(1, 32'h00400008, 6'h03, 6'h04, 5'd0, 5'd0, 5'd16, 5'd31, 32'd0, 32'd0, 32'h00000004, 32'h00400010, 1, 0)});
        vecs.push_back('{32'h00000020, 32'h00400020, 1, 1, 5'd0, 32'h12345678,
            mk(1, 32'h00400020, 6'h00, 6'h20, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h00000020, 32'h00000080, 0, 0)});
        vecs.push_back('{32'h00000020, 32'h00400024, 1, 0, 5'd0, 32'h0,
            mk(1, 32'h00400024, 6'h00, 6'h20, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h00000020, 32'h00000080, 0, 0)});
        vecs.push_back('{32'hFC000000, 32'h00400028, 1, 0, 5'd0, 32'h0,
            mk(1, 32'h00400028, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h0, 32'h0, 0, 1)});
        vecs.push_back('{32'h03E00008, 32'h0040002C, 1, 0, 5'd0, 32'h0,
            mk(1, 32'h0040002C, 6'h00, 6'h08, 5'd0, 5'd31, 5'd0, 5'd0, 32'd0, 32'd0, 32'h00000008, 32'h0F800020, 0, 0)});
        vecs.push_back('{32'hAC220004, 32'h00400030, 1, 0, 5'd0, 32'h0,
            mk(1, 32'h00400030, 6'h2B, 6'h04, 5'd0, 5'd1, 5'd2, 5'd0, 32'hDEADBEEF, 32'd7, 32'h00000004, 32'h00880010, 0, 0)});
        vecs.push_back('{32'h00221820, 32'h00400034, 0, 0, 5'd0, 32'h0, out_t'(0)});
        vecs.push_back('{32'h08000001, 32'hFFFFFFFC, 1, 0, 5'd0, 32'h0,
            mk(1, 32'hFFFFFFFC, 6'h02, 6'h01, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h00000001, 32'h00000004, 0, 0)});
        vecs.push_back('{32'h0BFFFFFF, 32'hF0000000, 1, 0, 5'd0, 32'h0,
            mk(1, 32'hF0000000, 6'h02, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFC, 0, 0)});
        vecs.push_back('{32'h30228000, 32'h00400034, 1, 0, 5'd0, 32'h0,
            mk(1, 32'h00400034, 6'h0C, 6'h00, 5'd0, 5'd1, 5'd2, 5'd2, 32'hDEADBEEF, 32'd7, 32'h00008000, 32'h008A0000, 1, 0)});
        vecs.push_back('{32'h8C200010, 32'h00400038, 1, 0, 5'd0, 32'h0,
            mk(1, 32'h00400038, 6'h23, 6'h10, 5'd0, 5'd1, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0, 32'h00000010, 32'h00800040, 0, 0)});

        #12;
        check("reset_state", out_t'(0));
        @(negedge clk);
        rst = 1'b1;

        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5);
        tick();
        check("preload_bubble", out_t'(0));
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd7);
        tick();

        foreach (vecs[n]) begin
            drive(vecs[n].instr, vecs[n].pc, vecs[n].ce, 1'b0, 1'b0,
                  vecs[n].we, vecs[n].waddr, vecs[n].wdata);
            tick();
            check($sformatf("vec%0d", n), vecs[n].exp);
        end

        // Stall with writebacks to the held source registers.
        drive(32'h00221820, 32'h00400100, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        hold = mk(1, 32'h00400100, 6'h00, 6'h20, 5'd0, 5'd1, 5'd2, 5'd3, 32'hDEADBEEF, 32'd7,
                  32'h00001820, 32'h00886080, 1, 0);
        check("stall_load", hold);
        for (int k = 0; k < 3; k++) begin
            drive(32'hFC000000, 32'h00500000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'h1000 + 32'(k));
            tick();
            hold.rs_data = 32'h1000 + 32'(k);
            check($sformatf("stall_rs%0d", k), hold);
        end
        drive(32'hFC000000, 32'h00500000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h2222);
        tick();
        hold.rt_data = 32'h2222;
        check("stall_rt", hold);
        drive(32'hFC000000, 32'h00500000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h3333);
        tick();
        check("stall_other", hold);
        drive(32'h00221820, 32'h00400104, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        check("stall_flush", out_t'(0));
        drive(32'h00221820, 32'h00400108, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check("resume", mk(1, 32'h00400108, 6'h00, 6'h20, 5'd0, 5'd1, 5'd2, 5'd3, 32'h1002, 32'h2222,
                           32'h00001820, 32'h00886080, 1, 0));

        // Asynchronous reset in the middle of a valid stream.
        #2;
        rst = 1'b0;
        #1;
        model_step();
        check("async_reset", out_t'(0));
        tick();
        check("reset_hold", out_t'(0));
        #2;
        rst = 1'b1;
        drive(32'h00221820, 32'h00400200, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        check("post_reset_read", mk(1, 32'h00400200, 6'h00, 6'h20, 5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0,
                                    32'h00001820, 32'h00886080, 1, 0));

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic [5:0]  ops [18];
            logic [31:0] ri;
            logic [4:0]  wa;
            ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                    6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h00, 6'h3F};
            ri = $urandom;
            ri[31:26] = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 17)];
            if (ri[31:26] == 6'h00 && $urandom_range(0, 3) == 0) ri[5:0] = 6'h08;
            wa = ($urandom_range(0, 1) == 0) ? m_q.rs : 5'($urandom);
            drive(ri, {$urandom, 2'b00} >> 2 << 2,
                  ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 7), 1'($urandom), wa, $urandom);
            tick();
            check("random", m_q);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Decode stage of the MIPS pipeline, directly downstream of `instruction_fetch`. It consumes `f_o_instr`, `f_o_pc` and `f_o_ce` and splits the 32-bit instruction into fields. It reads both source operands from an internal 32-entry register file and extends the immediate. It registers everything into the decode/execute pipeline register with one cycle of latency, and accepts a writeback port for register-file updates.

## Interface
Parameters:
- `IWIDTH`, 32, instruction width
- `PC_WIDTH`, 32, PC width
- `DWIDTH`, 32, register data width
- `AWIDTH`, 5, register address width

Ports:
- `d_clk`  in  1  clock, rising edge
- `d_rst`  in  1  reset, asynchronous, active-low
- `d_i_ce`  in  1  valid instruction from fetch
- `d_i_instr`  in  IWIDTH  instruction from fetch
- `d_i_pc`  in  PC_WIDTH  PC of `d_i_instr`
- `d_i_stall`  in  1  hold pipeline register
- `d_i_flush`  in  1  insert bubble
- `d_i_we`  in  1  writeback enable
- `d_i_waddr`  in  AWIDTH  writeback register
- `d_i_wdata`  in  DWIDTH  writeback data
- `d_o_ce`  out  1  outputs valid
- `d_o_pc`  out  PC_WIDTH  registered PC
- `d_o_opcode`  out  6  instr[31:26]
- `d_o_funct`  out  6  instr[5:0]
- `d_o_shamt`  out  5  instr[10:6]
- `d_o_rs_addr`, `d_o_rt_addr`  out  AWIDTH  source registers
- `d_o_rd_addr`  out  AWIDTH  destination register, resolved
- `d_o_rs_data`, `d_o_rt_data`  out  DWIDTH  operand values
- `d_o_imm`  out  DWIDTH  extended immediate
- `d_o_jump_target`  out  PC_WIDTH  J/JAL target
- `d_o_reg_write`  out  1  instruction writes `d_o_rd_addr`
- `d_o_illegal`  out  1  unsupported opcode

## Operation
- **Register file**
  - 32 × DWIDTH, two combinational reads (rs = instr[25:21], rt = instr[20:16]) and one synchronous write on `d_clk` when `d_i_we`.
  - Register 0 always reads 0; writes to it are ignored.
  - Write-through bypass: if `d_i_we` and `d_i_waddr` equals a nonzero read address, the read returns `d_i_wdata` in the same cycle.
- **Immediate**
  - Zero-extend for ANDI 0x0C, ORI 0x0D, XORI 0x0E.
  - LUI 0x0F gives {imm16, 16'h0}.
  - All other opcodes sign-extend.
- **Jump target**: {(`d_i_pc`+4)[31:28], instr[25:0], 2'b00}.
- **Destination and write enable**
  - R-type (op 0x00): dest = rd.
  - ADDI–LUI (0x08–0x0F) and LW 0x23: dest = rt.
  - JAL 0x03: dest = 31.
  - J 0x02, BEQ 0x04, BNE 0x05, SW 0x2B: `d_o_reg_write` = 0.
  - JR (R-type, funct 0x08): `d_o_reg_write` = 0.
  - `d_o_reg_write` is forced to 0 whenever dest = 0.
  - Any other opcode: `d_o_illegal` = 1 and `d_o_reg_write` = 0.
- **Pipeline register update, per rising edge in priority order**
  1. `d_i_flush`: bubble. `d_o_ce`=0 and all other outputs 0. Flush overrides stall.
  2. `d_i_stall`: hold all outputs. Exception: if `d_i_we` and `d_i_waddr` is nonzero and equals the held `d_o_rs_addr` (or `d_o_rt_addr`), the corresponding held data takes `d_i_wdata`.
  3. `!d_i_ce`: bubble, same as flush.
  4. Otherwise: load the decoded fields; `d_o_ce`=1.
- Writeback to the register file happens regardless of stall or flush.

## Timing
- Reset (`d_rst`=0, asynchronous): all outputs 0 immediately and all registers cleared to 0; this holds for as long as `d_rst` is low.
- Reset asserted mid-operation discards the in-flight instruction.
- First valid output appears on the first edge after `d_rst` rises with `d_i_ce`=1.
- Latency is 1 cycle from `d_i_instr`/`d_i_ce` to `d_o_*`. Throughput is one instruction per cycle when not stalled.
- Writeback and read of the same register on the same edge: the new value is captured, via the bypass.
- Back-to-back writes to the same register: the last write wins.
- Upstream fetch must hold `d_i_instr`, `d_i_pc` and `d_i_ce` while `d_i_stall`=1; decode does not buffer.

## Structure
- The shared MIPS package/header holds the opcode constants (R_TYPE, J, JAL, BEQ, BNE, ADDI…LUI, LW, SW), funct JR, and the default widths; fetch and execute use the same constants.
- Sub-module `register_file` contains the 2R1W array, its async clear, the zero-register rule and the bypass.
- `instruction_decode` contains the field decode, extension, jump target and pipeline register.

## Test plan
- **R-type ADD**: preload r1=5, r2=7; drive 0x00221820 at pc 0x00400000 with ce=1. Next cycle: ce=1, opcode 0, funct 0x20, rs=1, rt=2, rd=3, rs_data=5, rt_data=7, reg_write=1.
- **Immediate extension**:
  - 0x2022FFFF → imm 0xFFFFFFFF, rd=2.
  - 0x3422FFFF → imm 0x0000FFFF.
  - 0x3C011234 → imm 0x12340000, rd=1.
- **Bypass**:
  - ADD 0x00221820 with same-cycle we=1, waddr=1, wdata=0xDEADBEEF → rs_data=0xDEADBEEF.
  - Write waddr=0, then read r0 → 0.
- **JAL**: 0x0C100004 at pc 0x00400008 → jump_target 0x00400010, rd=31, reg_write=1.
- **Stall, flush and illegal**:
  - Stall held 3 cycles with a writeback to the held rs → outputs frozen except rs_data, which updates.
  - Stall and flush together → ce=0.
  - Opcode 0x3F → illegal=1, reg_write=0.
- **Reset mid-stream**: pull `d_rst` low between edges → all outputs 0 without waiting for a clock edge; the register file then reads 0.
